// File: rtl/sample_iterator_pkg.sv
// -----------------------------------------------------------------------------
// sample_iterator_pkg
// Shared raster definitions used by the sample iterator (and the downstream
// jitter/hash stage, which reuses the same one-hot MSAA encoding).
//   - DEF_* localparams : default word/geometry sizes for the raster pipe
//   - iter_state_t      : iterator FSM states
//   - subsample_step()  : one-hot MSAA select -> sample pitch in fixed point
// Optional feature macro used by this slice: SAMPLE_ITER_BACK2BACK_EN
// -----------------------------------------------------------------------------
package sample_iterator_pkg;

   localparam int DEF_SIGFIG = 24;  // fixed-point word width
   localparam int DEF_RADIX  = 10;  // fractional bits, 1 pixel = 1<<RADIX
   localparam int DEF_VERTS  = 3;
   localparam int DEF_AXIS   = 3;
   localparam int DEF_COLORS = 3;

   typedef enum logic {
      WAIT_STATE = 1'b0,
      TEST_STATE = 1'b1
   } iter_state_t;

   // [3]=1x, [2]=4x, [1]=16x, [0]=64x MSAA; pitch halves per step down.
   // A non-one-hot select has no meaningful pitch and returns zero.
   function automatic int unsigned subsample_step(input logic [3:0] sub_sample,
                                                  input int          radix);
      case (sub_sample)
         4'b1000: return 32'd1 << radix;
         4'b0100: return 32'd1 << (radix - 1);
         4'b0010: return 32'd1 << (radix - 2);
         4'b0001: return 32'd1 << (radix - 3);
         default: return 32'd0;
      endcase
   endfunction

endpackage

// File: rtl/sample_iterator_if.sv
// -----------------------------------------------------------------------------
// sample_iterator_if
// Bus between the bbox stage (R13), the sample iterator and the jitter/hash
// stage (R14).
//   R13 side : tri_R13S, color_R13U, box_R13S, validTri_R13H, halt_RnnnnL
//   R14 side : tri_R14S, color_R14U, sample_R14S, validSamp_R14H
// Modports:
//   master : environment view (drives R13, observes halt and R14)
//   slave  : iterator view (consumes R13, drives halt and R14)
// box_R13S[0] = LL corner, [1] = UR corner; [c][0] = x, [c][1] = y.
// -----------------------------------------------------------------------------
interface sample_iterator_if
   import sample_iterator_pkg::*;
#(
   parameter int SIGFIG = DEF_SIGFIG,
   parameter int VERTS  = DEF_VERTS,
   parameter int AXIS   = DEF_AXIS,
   parameter int COLORS = DEF_COLORS
);
   logic signed [SIGFIG-1:0] tri_R13S    [VERTS][AXIS];
   logic        [SIGFIG-1:0] color_R13U  [COLORS];
   logic signed [SIGFIG-1:0] box_R13S    [2][2];
   logic                     validTri_R13H;
   logic                     halt_RnnnnL;

   logic signed [SIGFIG-1:0] tri_R14S    [VERTS][AXIS];
   logic        [SIGFIG-1:0] color_R14U  [COLORS];
   logic signed [SIGFIG-1:0] sample_R14S [2];
   logic                     validSamp_R14H;

   modport master (
      output tri_R13S, color_R13U, box_R13S, validTri_R13H,
      input  halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
   );

   modport slave (
      input  tri_R13S, color_R13U, box_R13S, validTri_R13H,
      output halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
   );
endinterface

// File: rtl/sample_iterator_step.sv
// -----------------------------------------------------------------------------
// sample_step
// Combinational next-position logic for the row-major box walk.
//   x_i, y_i        : current sample position
//   ll_x_i, ll_y_i  : lower-left corner of the box
//   ur_x_i, ur_y_i  : upper-right corner of the box
//   step_i          : sample pitch
//   next_x_o/_y_o   : position of the following sample
//   last_H_o        : current position is the final sample of the box
// All comparisons are signed over the full word.
// -----------------------------------------------------------------------------
module sample_step
   import sample_iterator_pkg::*;
#(
   parameter int SIGFIG = DEF_SIGFIG
) (
   input  logic signed [SIGFIG-1:0] x_i,
   input  logic signed [SIGFIG-1:0] y_i,
   input  logic signed [SIGFIG-1:0] ll_x_i,
   input  logic signed [SIGFIG-1:0] ll_y_i,
   input  logic signed [SIGFIG-1:0] ur_x_i,
   input  logic signed [SIGFIG-1:0] ur_y_i,
   input  logic signed [SIGFIG-1:0] step_i,
   output logic signed [SIGFIG-1:0] next_x_o,
   output logic signed [SIGFIG-1:0] next_y_o,
   output logic                     last_H_o
);

   always_comb begin
      // NOTE: defaults first so every path assigns every output (no latches).
      next_x_o = x_i;
      next_y_o = y_i;
      last_H_o = 1'b0;
      if ((ll_x_i > ur_x_i) || (ll_y_i > ur_y_i)) begin
         // Inverted box: only the LL sample exists, never wrap rows.
         last_H_o = 1'b1;
      end else if (x_i < ur_x_i) begin
         next_x_o = x_i + step_i;
      end else if (y_i < ur_y_i) begin
         next_x_o = ll_x_i;
         next_y_o = y_i + step_i;
      end else begin
         last_H_o = 1'b1;
      end
   end

endmodule

// File: rtl/sample_iterator.sv
// -----------------------------------------------------------------------------
// sample_iterator
// Raster stage R13 -> R14. Accepts a triangle and its subsample-aligned
// bounding box, then walks the box row-major at the MSAA pitch, emitting one
// candidate sample per cycle with the triangle and colour held alongside.
//   clk              : clock
//   rst              : synchronous active-high reset
//   subSample_RnnnnU : one-hot MSAA select, sampled when a triangle is accepted
//   bus (slave)      : R13 inputs, halt_RnnnnL back-pressure, R14 outputs
// halt_RnnnnL is a decode of registered state only (no input->output path).
// Optional feature: SAMPLE_ITER_BACK2BACK_EN -- also raise halt in the cycle
// showing the last sample and accept the next triangle then, removing the
// bubble cycle between triangles.
// -----------------------------------------------------------------------------
module sample_iterator
   import sample_iterator_pkg::*;
#(
   parameter int SIGFIG = DEF_SIGFIG,
   parameter int RADIX  = DEF_RADIX,
   parameter int VERTS  = DEF_VERTS,
   parameter int AXIS   = DEF_AXIS,
   parameter int COLORS = DEF_COLORS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        subSample_RnnnnU,
   sample_iterator_if.slave  bus
);

   iter_state_t              state_q;
   logic signed [SIGFIG-1:0] tri_q   [VERTS][AXIS];
   logic        [SIGFIG-1:0] color_q [COLORS];
   logic signed [SIGFIG-1:0] ll_x_q, ll_y_q, ur_x_q, ur_y_q, step_q;
   logic signed [SIGFIG-1:0] x_q, y_q;
   logic signed [SIGFIG-1:0] x_d, y_d;
   logic                     valid_q;
   logic                     last_h;
   logic                     halt;
   logic                     accept;

   sample_step #(.SIGFIG(SIGFIG)) u_step (
      .x_i      (x_q),
      .y_i      (y_q),
      .ll_x_i   (ll_x_q),
      .ll_y_i   (ll_y_q),
      .ur_x_i   (ur_x_q),
      .ur_y_i   (ur_y_q),
      .step_i   (step_q),
      .next_x_o (x_d),
      .next_y_o (y_d),
      .last_H_o (last_h)
   );

`ifdef SAMPLE_ITER_BACK2BACK_EN
   // last_h depends only on registered position/box, so halt stays free of
   // any combinational path from the R13 inputs.
   assign halt = (state_q == WAIT_STATE) || last_h;
`else
   assign halt = (state_q == WAIT_STATE);
`endif

   // Upstream presents a triangle and we are ready for one.
   assign accept = bus.validTri_R13H & halt;

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: these registers drive outputs that must read zero after
         // reset, so unlike a storage array they are cleared explicitly.
         state_q <= WAIT_STATE;
         tri_q   <= '{default: '0};
         color_q <= '{default: '0};
         ll_x_q  <= '0;
         ll_y_q  <= '0;
         ur_x_q  <= '0;
         ur_y_q  <= '0;
         step_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         valid_q <= 1'b0;
      end else if (accept) begin
         // NOTE: non-blocking updates so every register sees pre-edge values.
         state_q <= TEST_STATE;
         tri_q   <= bus.tri_R13S;
         color_q <= bus.color_R13U;
         ll_x_q  <= bus.box_R13S[0][0];
         ll_y_q  <= bus.box_R13S[0][1];
         ur_x_q  <= bus.box_R13S[1][0];
         ur_y_q  <= bus.box_R13S[1][1];
         step_q  <= SIGFIG'(subsample_step(subSample_RnnnnU, RADIX));
         x_q     <= bus.box_R13S[0][0];
         y_q     <= bus.box_R13S[0][1];
         valid_q <= 1'b1;
      end else if ((state_q == TEST_STATE) && !last_h) begin
         x_q <= x_d;
         y_q <= y_d;
      end else begin
         // Idle in WAIT, or retire the last sample; position is held.
         state_q <= WAIT_STATE;
         valid_q <= 1'b0;
      end
   end

   // An accepted triangle must carry a legal one-hot MSAA select.
   a_onehot_step : assert property (@(posedge clk) disable iff (rst)
      accept |-> $onehot(subSample_RnnnnU));

   assign bus.halt_RnnnnL    = halt;
   assign bus.tri_R14S       = tri_q;
   assign bus.color_R14U     = color_q;
   assign bus.sample_R14S[0] = x_q;
   assign bus.sample_R14S[1] = y_q;
   assign bus.validSamp_R14H = valid_q;

endmodule

// File: tb/tb_sample_iterator.sv
// -----------------------------------------------------------------------------
// tb_sample_iterator
// Directed bench for sample_iterator: reset state, MSAA1/MSAA4 walks, zero
// box, back-to-back triangle hand-over, reset mid-walk, signed coordinates and
// upstream changes while halted. Expected sample lists are written out by hand.
// Build with +define+SAMPLE_ITER_BACK2BACK_EN to check the no-bubble variant.
// -----------------------------------------------------------------------------
module tb_sample_iterator;
   import sample_iterator_pkg::*;

   logic       clk;
   logic       rst;
   logic [3:0] sub_sample;

   int total = 0;
   int bad   = 0;

   int ex [8];
   int ey [8];

   sample_iterator_if bus ();

   sample_iterator dut (
      .clk              (clk),
      .rst              (rst),
      .subSample_RnnnnU (sub_sample),
      .bus              (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one edge; outputs are then observed 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present triangle "seed" with the given box on the R13 bus.
   task automatic load_tri(input int seed, input int llx, input int lly,
                           input int urx, input int ury);
      for (int v = 0; v < DEF_VERTS; v++)
         for (int a = 0; a < DEF_AXIS; a++)
            bus.tri_R13S[v][a] = 24'(seed * 100 + v * 10 + a);
      for (int c = 0; c < DEF_COLORS; c++)
         bus.color_R13U[c] = 24'(seed * 1000 + c);
      bus.box_R13S[0][0] = 24'(llx);
      bus.box_R13S[0][1] = 24'(lly);
      bus.box_R13S[1][0] = 24'(urx);
      bus.box_R13S[1][1] = 24'(ury);
   endtask

   // Check n consecutive samples against ex/ey for triangle "seed".
   // idle_after: also check the following cycle is idle (valid=0, halt=1).
   task automatic walk(input string tag, input int seed, input int n,
                       input bit idle_after);
      bit b2b;
`ifdef SAMPLE_ITER_BACK2BACK_EN
      b2b = 1'b1;
`else
      b2b = 1'b0;
`endif
      for (int i = 0; i < n; i++) begin
         check({tag, ".valid"}, bus.validSamp_R14H, 1);
         check({tag, ".x"},     bus.sample_R14S[0], ex[i]);
         check({tag, ".y"},     bus.sample_R14S[1], ey[i]);
         check({tag, ".halt"},  bus.halt_RnnnnL, (b2b && i == n - 1) ? 1 : 0);
         check({tag, ".tri21"}, bus.tri_R14S[2][1], seed * 100 + 21);
         check({tag, ".col2"},  bus.color_R14U[2], seed * 1000 + 2);
         tick();
      end
      if (idle_after) begin
         check({tag, ".end_valid"}, bus.validSamp_R14H, 0);
         check({tag, ".end_halt"},  bus.halt_RnnnnL, 1);
      end
   endtask

   // With a valid triangle held: default build shows one bubble before the
   // accept edge; the back-to-back build already accepted it in walk().
   task automatic handover(input string tag);
`ifndef SAMPLE_ITER_BACK2BACK_EN
      check({tag, ".bubble_valid"}, bus.validSamp_R14H, 0);
      check({tag, ".bubble_halt"},  bus.halt_RnnnnL, 1);
      tick();
`endif
      bus.validTri_R13H = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      sub_sample = 4'b1000;
      bus.validTri_R13H = 1'b0;
      load_tri(0, 0, 0, 0, 0);

      // Reset-only
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst.halt",  bus.halt_RnnnnL, 1);
      check("rst.valid", bus.validSamp_R14H, 0);
      check("rst.x",     bus.sample_R14S[0], 0);
      check("rst.y",     bus.sample_R14S[1], 0);
      check("rst.tri",   bus.tri_R14S[0][0], 0);
      check("rst.col",   bus.color_R14U[0], 0);

      // MSAA1, 3x2 samples
      load_tri(1, 0, 0, 2048, 1024);
      sub_sample = 4'b1000;
      bus.validTri_R13H = 1'b1;
      tick();
      bus.validTri_R13H = 1'b0;
      ex = '{0, 1024, 2048, 0, 1024, 2048, 0, 0};
      ey = '{0, 0, 0, 1024, 1024, 1024, 0, 0};
      walk("msaa1", 1, 6, 1'b1);

      // MSAA4, 2x2 samples at pitch 512
      load_tri(2, 1024, 1024, 1536, 1536);
      sub_sample = 4'b0100;
      bus.validTri_R13H = 1'b1;
      tick();
      bus.validTri_R13H = 1'b0;
      ex = '{1024, 1536, 1024, 1536, 0, 0, 0, 0};
      ey = '{1024, 1024, 1536, 1536, 0, 0, 0, 0};
      walk("msaa4", 2, 4, 1'b1);

      // Zero box, then a second triangle held valid for hand-over
      load_tri(3, 3072, 2048, 3072, 2048);
      sub_sample = 4'b1000;
      bus.validTri_R13H = 1'b1;
      tick();
      load_tri(4, 0, 0, 1024, 0);
      ex = '{3072, 0, 0, 0, 0, 0, 0, 0};
      ey = '{2048, 0, 0, 0, 0, 0, 0, 0};
      walk("zero", 3, 1, 1'b0);
      handover("zero");
      ex = '{0, 1024, 0, 0, 0, 0, 0, 0};
      ey = '{0, 0, 0, 0, 0, 0, 0, 0};
      walk("next", 4, 2, 1'b1);

      // Reset on the 3rd sample of a 6-sample walk
      load_tri(5, 0, 0, 2048, 1024);
      bus.validTri_R13H = 1'b1;
      tick();
      bus.validTri_R13H = 1'b0;
      ex = '{0, 1024, 2048, 0, 0, 0, 0, 0};
      ey = '{0, 0, 0, 0, 0, 0, 0, 0};
      walk("prerst", 5, 2, 1'b0);
      check("midrst.x", bus.sample_R14S[0], 2048);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst.valid", bus.validSamp_R14H, 0);
      check("midrst.halt",  bus.halt_RnnnnL, 1);
      check("midrst.tri",   bus.tri_R14S[2][1], 0);
      tick();
      check("midrst.valid2", bus.validSamp_R14H, 0);

      // New triangle after reset, negative (signed) coordinates
      load_tri(6, -2048, -1024, -1024, -1024);
      bus.validTri_R13H = 1'b1;
      tick();
      bus.validTri_R13H = 1'b0;
      ex = '{-2048, -1024, 0, 0, 0, 0, 0, 0};
      ey = '{-1024, -1024, 0, 0, 0, 0, 0, 0};
      walk("neg", 6, 2, 1'b1);

      // Upstream changes while halted must not disturb the walk
      load_tri(7, 0, 0, 512, 0);
      sub_sample = 4'b0100;
      bus.validTri_R13H = 1'b1;
      tick();
      load_tri(8, 4096, 4096, 4096, 4096);
      sub_sample = 4'b1000;
      ex = '{0, 512, 0, 0, 0, 0, 0, 0};
      ey = '{0, 0, 0, 0, 0, 0, 0, 0};
      walk("hold", 7, 2, 1'b0);
      handover("hold");
      ex = '{4096, 0, 0, 0, 0, 0, 0, 0};
      ey = '{4096, 0, 0, 0, 0, 0, 0, 0};
      walk("held", 8, 1, 1'b1);

      // Inverted box: only the LL sample
      load_tri(9, 2048, 0, 1024, 2048);
      bus.validTri_R13H = 1'b1;
      tick();
      bus.validTri_R13H = 1'b0;
      ex = '{2048, 0, 0, 0, 0, 0, 0, 0};
      ey = '{0, 0, 0, 0, 0, 0, 0, 0};
      walk("inv", 9, 1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sample_iterator.md
Name: sample_iterator

Overview:
- Raster stage R13→R14, directly upstream of the jitter/hash stage.
- Accepts one triangle plus its subsample-aligned bounding box from the bbox stage.
- Walks the box in row-major order at the current subsample pitch, emitting one candidate sample per cycle with the triangle and colour held alongside.
- Stalls the bbox stage via `halt_RnnnnL` while the walk is in progress.

Parameters:
- `SIGFIG`, 24: fixed-point word width.
- `RADIX`, 10: fractional bits (1 pixel = 1<<RADIX).
- `VERTS`, 3: vertices per triangle.
- `AXIS`, 3: coordinates per vertex.
- `COLORS`, 3: colour channels.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `tri_R13S` in [VERTS][AXIS]×SIGFIG signed: triangle from bbox.
- `color_R13U` in [COLORS]×SIGFIG: triangle colour.
- `box_R13S` in [2][2]×SIGFIG signed: [0]=LL, [1]=UR corner; [c][0]=x, [c][1]=y.
- `validTri_R13H` in 1: triangle/box valid.
- `subSample_RnnnnU` in 4: one-hot MSAA select ([3]=1, [2]=4, [1]=16, [0]=64).
- `halt_RnnnnL` out 1: low = upstream must hold its R13 outputs.
- `tri_R14S` out [VERTS][AXIS]×SIGFIG signed: held triangle.
- `color_R14U` out [COLORS]×SIGFIG: held colour.
- `sample_R14S` out [2]×SIGFIG signed: sample x,y.
- `validSamp_R14H` out 1: sample valid.

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous, active-high.
- Reset state: WAIT. All outputs zero except `halt_RnnnnL`=1. Reset mid-walk abandons the triangle; no further samples are emitted.
- Step size from `subSample_RnnnnU`:
  - [3]: 1<<RADIX
  - [2]: 1<<(RADIX-1)
  - [1]: 1<<(RADIX-2)
  - [0]: 1<<(RADIX-3)
  - Step is sampled at triangle accept and held for the whole walk. Non-one-hot input is illegal; an assertion fires.
- `halt_RnnnnL` is a decode of the state register only (no combinational path from inputs): 1 in WAIT, 0 in TEST.
- WAIT:
  - Accept when `validTri_R13H`=1.
  - Register tri, colour, box and step; set `sample_R14S`=LL; set `validSamp_R14H`=1; go to TEST. The first sample is visible the cycle after accept (latency 1).
  - If `validTri_R13H`=0, `validSamp_R14H`=0 and the sample register holds.
- TEST, one sample per cycle:
  - If x < UR.x: x += step.
  - Else if y < UR.y: x = LL.x, y += step.
  - Else (last sample): `validSamp_R14H`←0, go to WAIT.
- Comparisons are signed, full SIGFIG. Adds are SIGFIG wide; overflow cannot occur because the box is screen-clipped upstream.
- Zero-extent box (LL==UR): exactly one sample, one TEST cycle.
- Box with LL>UR on either axis: no wraparound; emits the single sample at LL.
- Sample count per triangle: (⌊(UR.x-LL.x)/step⌋+1)·(⌊(UR.y-LL.y)/step⌋+1).
- Default mode has one bubble cycle between triangles: WAIT always lasts at least one cycle after the last sample.
- Triangle and colour outputs change only on accept; they are stable for every sample of that triangle.

Optional Feature:
- Macro: `SAMPLE_ITER_BACK2BACK_EN`.
- Defined:
  - `halt_RnnnnL`=1 also in the TEST cycle that issues the last sample (computed from registered position vs. UR, still no input→output combinational path).
  - A valid triangle present in that cycle is accepted directly.
  - Its LL sample follows the previous last sample with no bubble; state stays TEST.
- Undefined: the behaviour above, with one bubble cycle per triangle.

Decomposition:
- Shared raster package holds:
  - the state enum `iter_state_t` {WAIT_STATE, TEST_STATE};
  - a function `subsample_step(subSample, RADIX)` returning the step. The hash stage reuses the same one-hot encoding.
- One natural sub-module, `sample_step`: combinational next-position/last-sample logic (inputs: current x,y, LL, UR, step; outputs: next x,y, `last_H`).
- All flops live in `sample_iterator`.

Test Plan:
- Reset-only: `rst`=1 for 3 cycles, then released with `validTri`=0 → `halt_RnnnnL`=1, `validSamp_R14H`=0, `sample_R14S`=0.
- MSAA1 (`subSample`=4'b1000), box LL(0,0) UR(2048,1024) → samples (0,0),(1024,0),(2048,0),(0,1024),(1024,1024),(2048,1024) on consecutive cycles; halt low for exactly 6 cycles; valid drops the next cycle.
- MSAA4 (4'b0100), LL(1024,1024) UR(1536,1536), step 512 → 4 samples (1024,1024),(1536,1024),(1024,1536),(1536,1536).
- Zero box LL=UR=(3072,2048) → single sample, halt low 1 cycle. Second triangle held with `validTri`=1 → accepted after a 1-cycle bubble (no bubble with `SAMPLE_ITER_BACK2BACK_EN`).
- Reset asserted on the 3rd sample of a 6-sample walk → the next cycle has valid=0 and halt=1, no further samples; a new triangle is then walked from its own LL.
- Upstream hold check: while halt=0, change `tri_R13S`/`box_R13S` → R14 triangle and samples unaffected; the changed triangle is accepted only when halt=1.
